// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the M-extension multiply/divide unit: opcode, funct7/funct3 values,
// FSM states and operand signedness helpers.
package ex_muldiv_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // MUL is run unsigned: its low half does not depend on operand signedness.
    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_MULHSU) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_fixup.sv
// Sign correction and result selection applied to the magnitude-domain product,
// quotient and remainder as the unit enters DONE.
module ex_muldiv_fixup
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic            neg1,
    input  logic            neg2,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // hi/lo hold {product} for multiplies and {remainder, quotient} for divides.
    always_comb begin
        prod     = {hi, lo};
        prod_fix = (neg1 ^ neg2) ? -prod : prod;
        quo_fix  = (neg1 ^ neg2) ? -lo : lo;
        rem_fix  = neg1 ? -hi : hi;
        case (funct3)
            INST_MUL:                           result = prod_fix[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            INST_DIV, INST_DIVU:                result = quo_fix;
            default:                            result = rem_fix;
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle register-file writeback.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       op1_i,
    input  logic [XLEN-1:0]       op2_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  hold_flag_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_wen_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e                state;
    logic [2:0]            funct3_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  neg1_q;
    logic                  neg2_q;
    logic [XLEN-1:0]       mag_q;
    logic [XLEN-1:0]       hi_q;
    logic [XLEN-1:0]       lo_q;
    logic [XLEN-1:0]       res_q;
    logic [CNT_W-1:0]      cnt_q;

    logic            is_div;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div   = funct3_i[2];
        neg1     = op1_signed(funct3_i) & op1_i[XLEN-1];
        neg2     = op2_signed(funct3_i) & op2_i[XLEN-1];
        abs1     = neg1 ? -op1_i : op1_i;
        abs2     = neg2 ? -op2_i : op2_i;
        div_zero = is_div & (op2_i == '0);
        div_ovf  = is_div & ~funct3_i[0] & (op1_i == XLEN_MIN) & (op2_i == '1);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero)
            special_res = funct3_i[1] ? op1_i : '1;
        else
            special_res = funct3_i[1] ? '0 : op1_i;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;

    // Multiply: lo holds the multiplier, shifted out LSB-first while product bits shift in.
    // Divide: lo holds the dividend, shifted out MSB-first while quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        if (funct3_q[2]) begin
            hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [XLEN-1:0] fix_res;

    ex_muldiv_fixup #(
        .XLEN(XLEN)
    ) u_fixup (
        .funct3 (funct3_q),
        .neg1   (neg1_q),
        .neg2   (neg2_q),
        .hi     (hi_step),
        .lo     (lo_step),
        .result (fix_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            funct3_q <= '0;
            rd_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            mag_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        funct3_q <= funct3_i;
                        rd_q     <= rd_addr_i;
                        neg1_q   <= neg1;
                        neg2_q   <= neg2;
                        cnt_q    <= '0;
                        hi_q     <= '0;
                        if (div_zero || div_ovf) begin
                            res_q <= special_res;
                            state <= DONE;
                        end else begin
                            mag_q <= is_div ? abs2 : abs1;
                            lo_q  <= is_div ? abs1 : abs2;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        hi_q  <= hi_step;
                        lo_q  <= lo_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            res_q <= fix_res;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Hold covers the issue cycle combinationally and drops in DONE so the pipeline
    // advances alongside the writeback.
    always_comb begin
        busy_o      = (state != IDLE);
        hold_flag_o = ((state == IDLE) & start_i & ~flush_i) | (state == CALC);
        rd_wen_o    = (state == DONE) & ~flush_i;
        rd_addr_o   = rd_wen_o ? rd_q : '0;
        rd_data_o   = rd_wen_o ? res_q : '0;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv at XLEN=32: scoreboarded writebacks against a
// native-arithmetic reference, latency/hold accounting, flush and reset behaviour.
module tb_ex_muldiv;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RW-1:0]   rd_addr;
    logic            flush;
    logic            busy_o;
    logic            hold_flag_o;
    logic [RW-1:0]   rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_wen_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW+XLEN-1:0] exp_q[$];
    logic [RW+XLEN-1:0] exp_e;

    ex_muldiv #(
        .XLEN       (XLEN),
        .REG_ADDR_W (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .funct3_i    (funct3),
        .op1_i       (op1),
        .op2_i       (op2),
        .rd_addr_i   (rd_addr),
        .flush_i     (flush),
        .busy_o      (busy_o),
        .hold_flag_o (hold_flag_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .rd_wen_o    (rd_wen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] p;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return $urandom_range(0, 20);
            1:       return 32'h0;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_wen_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_wen", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rd_data", rd_data_o, exp_e[XLEN-1:0]);
                check("rd_addr", rd_addr_o, exp_e[RW+XLEN-1:XLEN]);
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [RW-1:0] rd, input bit poke);
        int  lat;
        int  cyc;
        int  hold_cnt;
        bit  special;
        special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        lat = special ? 1 : 33;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op1 = a; op2 = b; rd_addr = rd;
        exp_q.push_back({rd, ref_model(f3, a, b)});
        #1;
        check("hold_issue", hold_flag_o, 1);
        @(posedge clk); #1;
        start    = 1'b0;
        hold_cnt = 1;
        cyc      = 1;
        while (!rd_wen_o && cyc < 100) begin
            if (hold_flag_o) hold_cnt++;
            start = poke && (cyc == 10);
            if (start) begin
                op1 = ~a; op2 = a ^ 32'h5A5A_5A5A; funct3 = ~f3; rd_addr = ~rd;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("timeout", (cyc < 100), 1);
        check("latency", cyc, lat);
        check("hold_cycles", hold_cnt, lat);
        check("hold_done", hold_flag_o, 0);
        @(posedge clk); #1;
        check("busy_after", busy_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0; flush = 1'b0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_hold", hold_flag_o, 0);
        check("rst_wen", rd_wen_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_addr", rd_addr_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed multiplies and divides.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 0);
        run_op(3'd4, -32'd7, 32'd2, 5'd9, 0);
        run_op(3'd6, -32'd7, 32'd2, 5'd10, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd11, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd12, 0);

        // Special cases with single-cycle latency.
        run_op(3'd4, 32'd5, 32'd0, 5'd13, 0);
        run_op(3'd7, 32'd5, 32'd0, 5'd14, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);

        // Flush in CALC drops the operation; next op is unaffected.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; rd_addr = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_wen", rd_wen_o, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_hold", hold_flag_o, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd21, 0);

        // Flush beats a simultaneous start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op1 = 32'd2; op2 = 32'd2;
        #1;
        check("flush_start_hold", hold_flag_o, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy_o, 0);

        // Asynchronous reset mid-multiply.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9; rd_addr = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_hold", hold_flag_o, 0);
        check("arst_wen", rd_wen_o, 0);
        check("arst_data", rd_data_o, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_idle", busy_o, 0);

        // Start pulsed during CALC must not disturb the running op.
        run_op(3'd0, 32'd123, 32'd456, 5'd17, 1);
        run_op(3'd4, -32'd1000, 32'd7, 5'd18, 1);

        for (int i = 0; i < 20; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 0);
        end

        repeat (3) @(posedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
